// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx_i, detects a start edge and samples start/data/parity/stop
// at mid-bit using a runtime baud limit. Define UART_RX_MAJORITY_EN for 3-sample majority voting.
module uart_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  input  logic              rx_en_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic [15:0]       bauds_lim_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_done_o,
  output logic              frame_err_o,
  output logic              parity_err_o
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     line, line_q, fall;
  logic [15:0]              cnt_q, lim_q, per;
  logic                     par_en_q, par_odd_q, par_err_q;
  logic [BIT_W-1:0]         bit_cnt_q;
  logic [DATA_W-1:0]        shreg_q;
  logic                     sample_pt, strobe, bit_s;

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      line_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain shifts by one stage per clock.
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      line_q <= line;
    end
  end

  assign line = sync_q[SYNC_STAGES-1];
  assign fall = line_q & ~line;
  assign per  = (lim_q < 16'd3) ? 16'd3 : lim_q;

  always_comb begin
    sample_pt = 1'b0;
    case (state_q)
      S_START:                  sample_pt = (cnt_q == (per >> 1));
      S_DATA, S_PARITY, S_STOP: sample_pt = (cnt_q == per);
      default:                  sample_pt = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  // The vote resolves one cycle after the sample point, so the counter restarts at 1 to keep bit timing aligned.
  localparam logic [15:0] CNT_RESTART = 16'd1;
  logic strobe_q, line_d1, line_d2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_q <= 1'b0;
      line_d1  <= 1'b1;
      line_d2  <= 1'b1;
    end else begin
      strobe_q <= sample_pt & rx_en_i;
      line_d1  <= line;
      line_d2  <= line_d1;
    end
  end

  assign strobe = strobe_q;
  assign bit_s  = (line_d2 & line_d1) | (line_d2 & line) | (line_d1 & line);
`else
  localparam logic [15:0] CNT_RESTART = 16'd0;
  assign strobe = sample_pt;
  assign bit_s  = line;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning the default first means every path drives state_d, so no latch is inferred.
    state_d = state_q;
    if (state_q != S_IDLE && !rx_en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (rx_en_i && fall) state_d = S_START;
        S_START:  if (strobe) state_d = bit_s ? S_IDLE : S_DATA;
        S_DATA:   if (strobe && bit_cnt_q == BIT_W'(DATA_W - 1))
                    state_d = par_en_q ? S_PARITY : S_STOP;
        S_PARITY: if (strobe) state_d = S_STOP;
        S_STOP:   if (strobe) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      lim_q     <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_err_q <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      if (state_d == S_IDLE)        cnt_q <= '0;
      else if (state_d != state_q)  cnt_q <= (state_q == S_IDLE) ? 16'd0 : CNT_RESTART;
      else if (cnt_q == per)        cnt_q <= '0;
      else                          cnt_q <= cnt_q + 16'd1;

      if (state_q == S_IDLE && state_d == S_START) begin
        lim_q     <= bauds_lim_i;
        par_en_q  <= parity_en_i;
        par_odd_q <= parity_odd_i;
      end

      if (state_q == S_DATA && strobe && rx_en_i) begin
        shreg_q   <= {bit_s, shreg_q[DATA_W-1:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end else if (state_q != S_DATA) begin
        bit_cnt_q <= '0;
      end

      if (state_q == S_PARITY && strobe)
        par_err_q <= (^shreg_q) ^ bit_s ^ par_odd_q;
    end
  end

  // Outputs change only on a completed frame and hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_data_o    <= '0;
      rx_done_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
    end else if (state_q == S_STOP && strobe && rx_en_i) begin
      rx_done_o    <= 1'b1;
      rx_data_o    <= shreg_q;
      frame_err_o  <= ~bit_s;
      parity_err_o <= par_en_q & par_err_q;
    end else begin
      rx_done_o    <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Standalone UART receiver: the serial-input end of the link driven by the team's UART transmitter.
- Deserialises the rx_i line into bytes: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Bit timing comes from the runtime baud limit bauds_lim_i, shared with the transmitter.
- Reports each byte with a one-cycle done pulse plus frame and parity error flags.

Parameters:
- DATA_W, 8, data bits per frame; sets rx_data_o width and the shift register length.
- SYNC_STAGES, 2, flops in the rx_i synchronizer; minimum 2.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- rx_i  in  1  serial line, idle high, asynchronous to clk_i
- rx_en_i  in  1  receiver enable; deasserting aborts any frame in progress
- parity_en_i  in  1  parity bit present after the data bits
- parity_odd_i  in  1  1 = odd parity, 0 = even
- bauds_lim_i  in  16  bit period minus 1, in clk_i cycles
- rx_data_o  out  DATA_W  last received byte
- rx_done_o  out  1  one-cycle pulse, byte complete
- frame_err_o  out  1  stop bit sampled low on the last frame
- parity_err_o  out  1  parity mismatch on the last frame

Behaviour:
- Reset: rx_data_o=0, rx_done_o=0, frame_err_o=0, parity_err_o=0. Synchronizer flops reset to 1. FSM=IDLE, counters=0.
- Sync: rx_i passes through SYNC_STAGES flops; "line" below means the synchronized value. A falling edge is prev=1, now=0 on the synced line.
- Config latch: parity_en_i, parity_odd_i and bauds_lim_i are captured on IDLE->START. Changes mid-frame are ignored.
- Period P = max(latched bauds_lim_i, 3) + 1 cycles. Values 0..2 are treated as 3.
- The baud counter runs 0..P-1 and restarts at 0 on every state change.
- IDLE:
  - rx_en_i=1 and falling edge -> START.
  - Otherwise stay in IDLE.
- START:
  - At count == (P-1)>>1, sample the line.
  - 0 -> DATA. 1 -> IDLE (glitch rejected, no flags change).
- DATA:
  - Sample at count == P-1, i.e. each mid-bit.
  - Shift each sample into bit DATA_W-1 of the shift register, shifting right, so the register ends LSB first.
  - After DATA_W samples: -> PARITY if parity enabled, else -> STOP.
- PARITY:
  - Sample at count == P-1.
  - Error = (XOR of data bits) ^ parity bit ^ parity_odd.
  - -> STOP.
- STOP:
  - Sample at count == P-1.
  - On the next cycle: rx_done_o=1 for exactly one cycle; rx_data_o, frame_err_o (=~stop sample) and parity_err_o (0 if parity disabled) update together.
  - -> IDLE.
- Outputs hold their values until the next rx_done_o.
- Receiving resumes from mid-stop. A new start needs a fresh falling edge, so a line held low (break) gives exactly one frame_err frame, then waits for the line to return high.
- rx_en_i=0 in any non-IDLE state: -> IDLE on the next cycle. No done pulse, outputs unchanged.
- Reset mid-frame: immediate return to the reset state; the partial byte is discarded.
- Latency: rx_done_o asserts SYNC_STAGES+1 cycles after the mid-stop-bit point on rx_i.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample (start, data, parity, stop) is the 2-of-3 majority of the synced line at sample points -1, 0 and +1 cycle.
  - The vote is resolved at sample point +1, so all sample-dependent events shift 1 cycle later.
  - Single-cycle glitches at the sample point are rejected.
- Undefined: a single sample at the sample point; no vote logic is present.

Test Plan:
- No parity: bauds_lim_i=15, send 0xA5, stop=1 -> exactly one rx_done_o pulse, rx_data_o=0xA5, frame_err_o=0, parity_err_o=0.
- Even parity: parity_en_i=1, parity_odd_i=0, send 0x03.
  - Parity bit 0 -> parity_err_o=0.
  - Resend with parity bit 1 -> parity_err_o=1, rx_data_o=0x03.
- Odd parity, bauds_lim_i=7, send 0x80 with parity bit 0 -> parity_err_o=0. Then stop bit driven 0 -> frame_err_o=1, rx_data_o=0x80. Line then held low 40 cycles -> no further rx_done_o until a high then a falling edge.
- Glitch: bauds_lim_i=15, rx_i low for 4 cycles then high -> no rx_done_o, FSM in IDLE. A following valid 0x5A is received correctly.
- Abort: drop rx_en_i after bit 3 of 0xFF -> no rx_done_o, outputs keep previous values. Re-enable and send 0x11 -> rx_data_o=0x11.
- Reset: assert rst_ni mid-DATA -> all outputs 0 immediately. After release, 0x3C is received correctly.
